// File: rtl/pipe_skid_reg_pkg.sv
// Shared defaults and counter-control decoding for the pipe_skid_reg stage register.
package pipe_skid_reg_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_CNT_W  = 16;

    // Counter action for one cycle; clear always beats increment.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_CLR  = 2'd2
    } cnt_op_e;

    function automatic cnt_op_e cnt_op(input logic clr, input logic inc);
        if (clr) begin
            return CNT_CLR;
        end
        if (inc) begin
            return CNT_INC;
        end
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready/payload handshake bundle between two pipeline stages.
interface pipe_skid_reg_if
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for stall/bubble statistics.
module pipe_sat_cnt
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    cnt_op_e op;

    // Decode this cycle's counter action.
    always_comb begin
        op = cnt_op(clr, inc);
    end

    // Count register: stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            unique case (op)
                CNT_CLR: cnt <= '0;
                CNT_INC: if (cnt != '1) cnt <= cnt + CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional skid entry,
// single-cycle flush, NOP payload on bubbles and saturating stall/bubble counters.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = PIPE_DATA_W,
    parameter bit                SKID      = 1'b1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = PIPE_CNT_W
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    input  logic             flush,
    pipe_skid_reg_if.slave   up,
    pipe_skid_reg_if.master  dn,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state;
    state_e            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              main_valid;
    logic              up_ready_int;
    logic              xfer_in;
    logic              xfer_out;
    logic              load_main_up;
    logic              load_main_skid;
    logic              load_skid;

    // Handshake qualifiers and downstream outputs (driven only from registers).
    always_comb begin
        main_valid = (state != EMPTY);
        xfer_out   = main_valid && dn.ready;
        xfer_in    = up.valid && up_ready_int;
        dn.valid   = main_valid;
        dn.data    = main_valid ? main_q : NOP_VALUE;
        up.ready   = up_ready_int;
    end

    generate
        if (SKID) begin : g_skid
            logic up_ready_q;

            // Registered ready: low only while both entries are occupied.
            always_ff @(posedge cpu_clk_50M) begin
                if (cpu_rst) begin
                    up_ready_q <= 1'b0;
                end else begin
                    up_ready_q <= (state_nxt != FULL);
                end
            end

            assign up_ready_int = up_ready_q;
        end else begin : g_noskid
            // Single entry: accept whenever the held entry leaves or none is held.
            always_comb begin
                up_ready_int = dn.ready || !main_valid;
            end
        end
    endgenerate

    // Next-state and entry-load decisions; flush discards everything incl. this cycle's input.
    // Without a skid entry, ONE with input-but-no-output cannot occur, so FULL is never reached.
    always_comb begin
        state_nxt      = state;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        state_nxt    = ONE;
                        load_main_up = 1'b1;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        load_main_up = 1'b1;
                    end else if (xfer_in) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (xfer_out) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer_out) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers; contents are masked by state so they need no reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (load_main_up) begin
            main_q <= up.data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= up.data;
        end
    end

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (cpu_clk_50M),
        .rst (cpu_rst),
        .clr (cnt_clr),
        .inc (main_valid && !dn.ready),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (cpu_clk_50M),
        .rst (cpu_rst),
        .clr (cnt_clr),
        .inc (!main_valid),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench: a SKID=1 stage (16-bit counters) and a SKID=0 stage (4-bit counters).
module tb_pipe_skid_reg;

    localparam logic [31:0] A_NOP = 32'h0000_0013;
    localparam logic [31:0] B_NOP = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_flush, a_clr, b_flush, b_clr;
    logic [15:0] a_stall, a_bubble;
    logic [3:0]  b_stall, b_bubble;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tog_data [6];
    logic        tog_rdy  [6];
    logic [31:0] nxt;

    pipe_skid_reg_if #(.DATA_W(32)) a_up ();
    pipe_skid_reg_if #(.DATA_W(32)) a_dn ();
    pipe_skid_reg_if #(.DATA_W(32)) b_up ();
    pipe_skid_reg_if #(.DATA_W(32)) b_dn ();

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(32), .SKID(1'b1), .NOP_VALUE(A_NOP), .CNT_W(16)) u_a (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .flush       (a_flush),
        .up          (a_up),
        .dn          (a_dn),
        .cnt_clr     (a_clr),
        .stall_cnt   (a_stall),
        .bubble_cnt  (a_bubble)
    );

    pipe_skid_reg #(.DATA_W(32), .SKID(1'b0), .NOP_VALUE(B_NOP), .CNT_W(4)) u_b (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .flush       (b_flush),
        .up          (b_up),
        .dn          (b_dn),
        .cnt_clr     (b_clr),
        .stall_cnt   (b_stall),
        .bubble_cnt  (b_bubble)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_clr = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
        a_up.valid = 1'b1; a_up.data = 32'hDEAD_BEEF; a_dn.ready = 1'b1;
        b_up.valid = 1'b0; b_up.data = '0;            b_dn.ready = 1'b0;

        // Reset held two cycles with an offer pending.
        tick(); tick();
        chk("rst_a_dn_valid", a_dn.valid, 1'b0);
        chk("rst_a_dn_data", a_dn.data, A_NOP);
        chk("rst_a_up_ready", a_up.ready, 1'b0);
        chk("rst_a_stall", a_stall, 16'd0);
        chk("rst_a_bubble", a_bubble, 16'd0);
        chk("rst_b_up_ready", b_up.ready, 1'b1);
        chk("rst_b_dn_data", b_dn.data, B_NOP);
        rst = 1'b0;
        tick();
        chk("rel_a_nothing_captured", a_dn.valid, 1'b0);
        chk("rel_a_up_ready", a_up.ready, 1'b1);

        // Streaming 1..8, counter clear on the first accept cycle.
        a_up.data = 32'd1; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("stream_valid", a_dn.valid, 1'b1);
            chk("stream_data", a_dn.data, 64'(i));
            chk("stream_up_ready", a_up.ready, 1'b1);
            chk("stream_bubble", a_bubble, 16'd0);
            if (i < 8) a_up.data = 32'(i + 1);
            else       a_up.valid = 1'b0;
            tick();
        end
        chk("stream_end_valid", a_dn.valid, 1'b0);
        chk("stream_end_nop", a_dn.data, A_NOP);
        chk("stream_end_stall", a_stall, 16'd0);

        // Backpressure: A, B fill both entries, C waits upstream.
        a_clr = 1'b1; a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 32'hA;
        tick();
        a_clr = 1'b0;
        chk("bp_one_data", a_dn.data, 32'hA);
        chk("bp_one_ready", a_up.ready, 1'b1);
        chk("bp_one_stall", a_stall, 16'd0);
        a_up.data = 32'hB;
        tick();
        chk("bp_full_ready", a_up.ready, 1'b0);
        chk("bp_full_data", a_dn.data, 32'hA);
        chk("bp_full_stall1", a_stall, 16'd1);
        a_up.data = 32'hC;
        tick();
        chk("bp_hold_ready", a_up.ready, 1'b0);
        chk("bp_hold_stall2", a_stall, 16'd2);
        tick();
        chk("bp_hold_data", a_dn.data, 32'hA);
        chk("bp_hold_stall3", a_stall, 16'd3);
        a_dn.ready = 1'b1;
        tick();
        chk("bp_rel_data_b", a_dn.data, 32'hB);
        chk("bp_rel_ready", a_up.ready, 1'b1);
        chk("bp_rel_stall", a_stall, 16'd3);
        tick();
        chk("bp_rel_data_c", a_dn.data, 32'hC);
        a_up.valid = 1'b0;
        tick();
        chk("bp_drained", a_dn.valid, 1'b0);
        chk("bp_stall_total", a_stall, 16'd3);

        // Flush while FULL with a new offer pending.
        a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 32'hA;
        tick();
        a_up.data = 32'hB;
        tick();
        chk("fl_full_ready", a_up.ready, 1'b0);
        a_flush = 1'b1; a_up.data = 32'hC;
        tick();
        a_flush = 1'b0; a_up.valid = 1'b0;
        chk("fl_valid", a_dn.valid, 1'b0);
        chk("fl_nop", a_dn.data, A_NOP);
        chk("fl_ready", a_up.ready, 1'b1);
        a_dn.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_reappear", a_dn.valid, 1'b0);
        end
        // Flush in ONE with simultaneous in and out: D delivered, E discarded.
        a_up.valid = 1'b1; a_up.data = 32'hD;
        tick();
        chk("fl2_data_d", a_dn.data, 32'hD);
        a_flush = 1'b1; a_up.data = 32'hE;
        tick();
        a_flush = 1'b0; a_up.valid = 1'b0;
        chk("fl2_e_dropped", a_dn.valid, 1'b0);
        tick();
        chk("fl2_still_empty", a_dn.valid, 1'b0);

        // Reset mid-stall.
        a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 32'h77;
        tick();
        a_up.data = 32'h78;
        tick();
        rst = 1'b1; a_up.valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rs_valid", a_dn.valid, 1'b0);
        chk("rs_stall", a_stall, 16'd0);
        chk("rs_ready_low", a_up.ready, 1'b0);
        tick();
        chk("rs_ready_high", a_up.ready, 1'b1);
        chk("rs_nop", a_dn.data, A_NOP);

        // Saturation on the 4-bit bubble counter.
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("sat_cleared", b_bubble, 4'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_bubble", b_bubble, 4'hF);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("sat_clr_wins", b_bubble, 4'd0);
        tick();
        chk("sat_resume", b_bubble, 4'd1);

        // SKID=0 with dn_ready toggling and continuous offers.
        tog_data[0] = B_NOP;    tog_rdy[0] = 1'b1;
        tog_data[1] = 32'h11;   tog_rdy[1] = 1'b0;
        tog_data[2] = 32'h11;   tog_rdy[2] = 1'b1;
        tog_data[3] = 32'h22;   tog_rdy[3] = 1'b0;
        tog_data[4] = 32'h22;   tog_rdy[4] = 1'b1;
        tog_data[5] = 32'h33;   tog_rdy[5] = 1'b0;
        nxt = 32'd1;
        for (int c = 0; c < 6; c++) begin
            b_dn.ready = ((c % 2) == 0);
            b_up.valid = 1'b1;
            b_up.data  = nxt * 32'h11;
            #1;
            chk("tog_valid", b_dn.valid, (c != 0));
            chk("tog_data", b_dn.data, tog_data[c]);
            chk("tog_up_ready", b_up.ready, tog_rdy[c]);
            tick();
            if (tog_rdy[c]) nxt = nxt + 32'd1;
        end
        b_up.valid = 1'b0; b_dn.ready = 1'b1;
        #1;
        chk("tog_last_data", b_dn.data, 32'h33);
        chk("tog_last_ready", b_up.ready, 1'b1);
        chk("tog_stall", b_stall, 4'd3);
        tick();
        chk("tog_empty", b_dn.valid, 1'b0);
        chk("tog_empty_nop", b_dn.data, B_NOP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register for the MiniMIPS32 core, replacing the fixed-field, stall-vector-driven stage registers with a generic payload and a valid/ready handshake. Sits between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). Provides an optional two-entry skid buffer so `up_ready` is registered, single-cycle flush for exceptions, NOP-forcing on bubbles, and saturating stall/bubble performance counters.

## Interface
- `DATA_W`, 32, payload width in bits (packed stage fields).
- `SKID`, 1, 1 = two-entry skid buffer with registered `up_ready`; 0 = single entry with combinational `up_ready`.
- `NOP_VALUE`, {DATA_W{1'b0}}, payload driven on `dn_data` whenever `dn_valid` = 0.
- `CNT_W`, 16, performance counter width.

- `cpu_clk_50M`  in  1  clock, all state on rising edge.
- `cpu_rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all held entries (exception/eret).
- `up_valid`  in  1  upstream offers payload.
- `up_ready`  out  1  this stage accepts payload.
- `up_data`  in  DATA_W  upstream payload.
- `dn_valid`  out  1  payload available downstream.
- `dn_ready`  in  1  downstream accepts payload.
- `dn_data`  out  DATA_W  payload to downstream.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `stall_cnt`  out  CNT_W  cycles with `dn_valid && !dn_ready`.
- `bubble_cnt`  out  CNT_W  cycles with `!dn_valid`.

## Operation
- Transfer in: `up_valid && up_ready`. Transfer out: `dn_valid && dn_ready`.
- Priority: `cpu_rst` > `flush` > transfers.
- SKID=1 states: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
  - EMPTY: in -> ONE.
  - ONE: in without out -> FULL (payload to skid); in with out -> ONE (main loads `up_data`); out only -> EMPTY.
  - FULL: `up_ready` = 0; out -> ONE (skid moves to main).
  - `up_ready` registered: 1 in EMPTY/ONE, 0 in FULL.
- SKID=0: single entry; `up_ready` = `dn_ready || !dn_valid` (combinational); in replaces main in same cycle as out.
- Ordering is strict FIFO; no payload is duplicated or dropped except by flush.
- `flush`: next state EMPTY; any transfer-in in the flush cycle is discarded; a transfer-out in the flush cycle still counts as delivered downstream.
- `dn_data` = main payload when valid, else `NOP_VALUE` (never stale data).
- Counters: saturate at all-ones, no wrap; `cnt_clr` and `cpu_rst` zero them; `cnt_clr` wins over increment in the same cycle; counters keep counting during `flush`.

## Timing
- Latency: payload accepted at edge N appears on `dn_data` after edge N (1 cycle) when stage was EMPTY or ONE-with-out.
- Throughput: 1 transfer/cycle sustained when `dn_ready` = 1.
- SKID=1: `up_ready` deasserts the cycle after FULL is entered; the skid entry absorbs the one in-flight transfer.
- Reset values: `dn_valid` 0, `dn_data` `NOP_VALUE`, `up_ready` 0 (SKID=1, first 1 in cycle after reset release) / 1 (SKID=0, combinational), both counters 0, state EMPTY.
- Reset or flush asserted mid-stall: entries lost, `dn_valid` 0 on next cycle.
- `dn_valid`/`dn_data` are registered outputs; no combinational path from `up_*` to `dn_*`.

## Structure
- NOP payload constants per stage (e.g. the ID/EXE NOP bundle using `NOP`, `MINIMIPS32_SLL`, `REG_NOP`, `EXC_NONE`) live in `defines.v`; stage wrappers build `NOP_VALUE` from them.
- Sub-module `pipe_sat_cnt` (parametrised width, inc/clr, saturating), instantiated twice.
- State encoding local to the module.

## Test plan
- Reset: hold `cpu_rst` 2 cycles with `up_valid`=1, `up_data`=0xDEADBEEF -> `dn_valid`=0, `dn_data`=NOP_VALUE, counters 0, nothing captured.
- Streaming: `dn_ready`=1, push 0x1..0x8 back-to-back -> `dn_data` 0x1..0x8 on consecutive cycles, 1-cycle latency, `bubble_cnt` unchanged during stream.
- Backpressure (SKID=1): push 0xA,0xB,0xC with `dn_ready`=0 -> FULL after 0xB, `up_ready`=0, 0xC held upstream; release -> 0xA,0xB,0xC in order, `stall_cnt` = stalled cycles.
- Flush: FULL with 0xA,0xB, assert `flush` with `up_valid`=1 `up_data`=0xC -> next cycle `dn_valid`=0, 0xA/0xB/0xC never appear.
- Saturation: CNT_W=4, hold `dn_valid`=0 20 cycles -> `bubble_cnt`=0xF; `cnt_clr` with bubble -> 0.
- SKID=0 variant: `dn_ready` toggling 1/0 with continuous input -> `up_ready` tracks `dn_ready || !dn_valid` same cycle, no loss or duplication.
